// File: rtl/apb_slave_mem.sv
// Word-addressed APB slave memory with a fixed wait-state count and error response.
// Accesses are latched in the setup phase; pready/pslverr are decoded from registers only.
module apb_slave_mem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so BASE_ADDR + DEPTH*4 cannot wrap at the top of the address space.
    localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(DEPTH * 4);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we;

    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      setup_idx;
    logic                  addr_err;

    assign offset    = paddr - BASE_ADDR;
    assign setup_idx = IDX_W'(offset >> 2);
    assign addr_err  = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) || ({1'b0, paddr} >= LIMIT);

    assign pready  = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign pslverr = pready && err_q;
    assign prdata  = prdata_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        err_d    = err_q;
        idx_d    = idx_q;
        prdata_d = prdata_q;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d  = ACCESS;
                    write_d  = pwrite;
                    err_d    = addr_err;
                    idx_d    = setup_idx;
                    cnt_d    = 4'(WAIT_STATES);
                    prdata_d = (!pwrite && !addr_err) ? mem_q[setup_idx] : '0;
                end
            end
            default: begin
                // Deselect mid-transfer is an abort: back to IDLE with no write.
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (penable) begin
                    state_d = IDLE;
                    mem_we  = write_q && !err_q;
                end
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            prdata_q <= prdata_d;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= pwdata;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: three instances with 0, 3 and 5 wait states share one bus,
// each selected by its own psel bit; a negedge monitor pops expected completions and compares.
module tb_apb_slave_mem;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;

    logic        pready_w  [3];
    logic [31:0] prdata_w  [3];
    logic        pslverr_w [3];

    always #5 pclk = ~pclk;

    apb_slave_mem #(.WAIT_STATES(0)) u_dut0 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[0]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready_w[0]), .prdata(prdata_w[0]),
        .pslverr(pslverr_w[0])
    );
    apb_slave_mem #(.WAIT_STATES(3)) u_dut1 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[1]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready_w[1]), .prdata(prdata_w[1]),
        .pslverr(pslverr_w[1])
    );
    apb_slave_mem #(.WAIT_STATES(5)) u_dut2 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[2]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready_w[2]), .prdata(prdata_w[2]),
        .pslverr(pslverr_w[2])
    );

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   ws [3] = '{0, 3, 5};
    int   n_chk = 0;
    int   n_pass = 0;
    int   cur = 0;
    bit   in_xfer = 1'b0;
    int   waits_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: counts not-ready access cycles, pops one expectation per completion.
    always @(negedge pclk) begin
        if (!presetn || !in_xfer) begin
            waits_seen = 0;
        end else if (psel[cur] && penable) begin
            if (pready_w[cur]) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_completion: got pready with empty scoreboard");
                end else begin
                    mon_e = sbq.pop_front();
                    check("wait_cycles", waits_seen, mon_e.waits);
                    check("pslverr", {31'd0, pslverr_w[cur]}, {31'd0, mon_e.err});
                    if (!mon_e.wr) check("prdata", prdata_w[cur], mon_e.rdata);
                end
                waits_seen = 0;
            end else begin
                check("pslverr_without_pready", {31'd0, pslverr_w[cur]}, 32'd0);
                waits_seen++;
            end
        end else begin
            waits_seen = 0;
        end
    end

    // One APB transfer on instance d; abort_after > 0 drops psel after that many access cycles.
    task automatic xfer(input int d, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int abort_after);
        exp_t e;
        int   n;
        bit   done;
        bit   aborted;
        if (abort_after == 0) begin
            e.wr = wr; e.rdata = exp_rd; e.err = exp_err; e.waits = ws[d];
            sbq.push_back(e);
        end
        cur = d; in_xfer = 1'b1;
        psel = 3'b000; psel[d] = 1'b1; penable = 1'b0;
        paddr = a; pwrite = wr; pwdata = wd;
        @(negedge pclk);
        check("setup_cycle_pready", {31'd0, pready_w[d]}, 32'd0);
        @(posedge pclk); #1;
        penable = 1'b1;
        n = 0; done = 1'b0; aborted = 1'b0;
        while (!done) begin
            @(negedge pclk);
            if (pready_w[d]) begin
                done = 1'b1;
            end else begin
                n++;
                if (abort_after != 0 && n == abort_after) begin
                    @(posedge pclk); #1;
                    psel = 3'b000; penable = 1'b0;
                    @(posedge pclk); #1;
                    done = 1'b1; aborted = 1'b1;
                end else if (n > 40) begin
                    n_chk++;
                    $display("FAIL pready_timeout: got no pready after %0d cycles expected %0d", n, ws[d]);
                    done = 1'b1;
                end
            end
        end
        if (!aborted) begin
            @(posedge pclk); #1;
            psel = 3'b000; penable = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        presetn = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0;
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;
        @(negedge pclk);
        for (int i = 0; i < 3; i++) begin
            check("reset_pready", {31'd0, pready_w[i]}, 32'd0);
            check("reset_pslverr", {31'd0, pslverr_w[i]}, 32'd0);
            check("reset_prdata", prdata_w[i], 32'd0);
        end
        @(posedge pclk); #1;
        xfer(0, 32'h00, 1'b0, 32'd0, 32'h0000_0000, 1'b0, 0);

        // Zero-wait write then read.
        xfer(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
        xfer(0, 32'h10, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);

        // Three wait states.
        xfer(1, 32'h3C, 1'b1, 32'h1234_5678, 32'd0, 1'b0, 0);
        xfer(1, 32'h3C, 1'b0, 32'd0, 32'h1234_5678, 1'b0, 0);

        // Misaligned and out-of-range accesses; both alias word 0 if wrongly written.
        xfer(0, 32'h102, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
        xfer(0, 32'h100, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
        xfer(0, 32'h100, 1'b0, 32'd0, 32'd0, 1'b1, 0);
        xfer(0, 32'h00, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        xfer(0, 32'h10, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);

        // Abort a five-wait write after two access cycles.
        xfer(2, 32'h20, 1'b1, 32'hAAAA_5555, 32'd0, 1'b0, 2);
        xfer(2, 32'h20, 1'b0, 32'd0, 32'd0, 1'b0, 0);

        // penable without a setup phase must not start a transfer.
        in_xfer = 1'b0; cur = 0;
        psel = 3'b001; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
        repeat (2) begin
            @(negedge pclk);
            check("penable_no_setup_pready", {31'd0, pready_w[0]}, 32'd0);
        end
        @(posedge pclk); #1;
        psel = 3'b000; penable = 1'b0;
        @(posedge pclk); #1;

        // Back-to-back writes and reads, data = address.
        for (int i = 0; i < 16; i++) xfer(0, 32'(i * 4), 1'b1, 32'(i * 4), 32'd0, 1'b0, 0);
        for (int i = 0; i < 16; i++) xfer(0, 32'(i * 4), 1'b0, 32'd0, 32'(i * 4), 1'b0, 0);

        // Asynchronous reset during the access phase of a write.
        in_xfer = 1'b0; cur = 0;
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h5A5A_5A5A;
        @(posedge pclk); #1;
        penable = 1'b1;
        #2;
        check("pre_reset_pready", {31'd0, pready_w[0]}, 32'd1);
        presetn = 1'b0;
        #1;
        check("async_reset_pready", {31'd0, pready_w[0]}, 32'd0);
        check("async_reset_pslverr", {31'd0, pslverr_w[0]}, 32'd0);
        check("async_reset_prdata", prdata_w[0], 32'd0);
        psel = 3'b000; penable = 1'b0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(0, 32'h24, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        xfer(0, 32'h10, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        xfer(1, 32'h3C, 1'b0, 32'd0, 32'd0, 1'b0, 0);

        repeat (5) @(posedge pclk);
        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
